magic_packet_checker: RTL and testbench
=======================================

Name: magic_packet_checker

Overview:
Output-side companion to the push-side magic-packet position tracker. It captures one designated "magic" data word as it is pushed into a FIFO under test and tracks that word's position from the head. It compares the FIFO's head data against the stored word on the exact pop that removes it, and reports a sticky mismatch/property flag for formal and simulation checking. It sits beside the FIFO, observing its push/pop/data ports without driving them.

Parameters:
DEPTH, 8, FIFO capacity in entries.
WIDTH, 8, data word width in bits.
CNTWID, $clog2(DEPTH)+1, width of the position/occupancy counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
push  input  1  FIFO write strobe
pop  input  1  FIFO read strobe
data_in  input  WIDTH  FIFO write data, sampled when push=1
data_out  input  WIDTH  FIFO head data, valid in the same cycle as pop (first-word-fall-through)
capture  input  1  designate the current push as the magic packet (free/nondeterministic input)
state  output  2  0=IDLE, 1=TRACK, 2=DONE
cnt  output  CNTWID  IDLE: FIFO occupancy; TRACK: number of entries ahead of the magic packet
magic_data  output  WIDTH  stored magic word
done  output  1  state==DONE
mismatch  output  1  sticky, magic packet exited with wrong data
count_err  output  1  sticky, push on full or pop on empty while in IDLE
prop_ok  output  1  ~mismatch, combinational

Behaviour:
- Reset (async, any time, including mid-TRACK): state=IDLE, cnt=0, magic_data=0, mismatch=0, count_err=0. Outputs take these values immediately on rst assertion.
- All updates happen on the rising edge. Latency is 1 cycle from a strobe to the counter/state change.
- IDLE, no capture:
  - next cnt = cnt + push - pop, modulo 2^CNTWID.
  - A push with cnt==DEPTH and no pop sets count_err.
  - A pop with cnt==0 sets count_err.
  - If an error is flagged, cnt still updates arithmetically.
- IDLE, capture=1 with push=1:
  - magic_data <= data_in.
  - The push is not counted, so next cnt = cnt - pop.
  - state <= TRACK.
  - The underflow rule still applies: pop at cnt==0 sets count_err, and the FSM still moves to TRACK with cnt held at 0.
- capture=1 with push=0 is ignored in every state.
- TRACK:
  - push is ignored; cnt never increments.
  - pop with cnt>0: cnt <= cnt-1.
  - pop with cnt==0: the magic packet is exiting. If data_out != magic_data, mismatch <= 1. state <= DONE. cnt holds at 0.
  - Capture is ignored.
- DONE: terminal until reset. cnt, magic_data and mismatch hold. push, pop and capture are ignored, and count_err is no longer updated.
- mismatch and count_err are sticky; only rst clears them.
- Only one magic packet is captured per reset epoch. The first qualifying capture wins.
- state encoding 3 is unreachable; if entered, the block returns to IDLE on the next edge.

Test Plan:
- Capture and exit with matching data:
  - Stimulus: push 0x11, 0x22, 0x33 (cnt=3), then push 0x5A with capture=1. Then pop three times (data_out 0x11, 0x22, 0x33), then pop once with data_out=0x5A.
  - Response: state=TRACK and cnt=3 after the capture; cnt steps 2, 1, 0 over the three pops; on the final pop state=DONE, done=1, mismatch=0, prop_ok=1.
- Wrong exit data:
  - Stimulus: same sequence as above, but the final pop has data_out=0x5B.
  - Response: mismatch=1, prop_ok=0, and both stay at those values through 5 further push/pop cycles.
- Simultaneous capture and pop:
  - Stimulus: at cnt=2, one cycle with push=1, capture=1, pop=1, data_in=0xC3.
  - Response: next cnt=1, state=TRACK, magic_data=0xC3.
- Capture into an empty FIFO:
  - Stimulus: from reset, push 0x77 with capture=1; next cycle pop with data_out=0x77.
  - Response: cnt=0 after the capture; done=1 and mismatch=0 after the pop; count_err=0.
- Occupancy errors in IDLE:
  - Stimulus: pop at cnt=0. Separately, perform DEPTH pushes, then a ninth push with no pop.
  - Response: count_err=1 in each case. Subsequent captures still work normally.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously, between clock edges, while in TRACK with cnt=2 and mismatch=0.
  - Response: state=0, cnt=0 and magic_data=0 with no clock edge required. A new capture after deassertion is accepted.

Source files
------------

// File: rtl/magic_packet_checker_if.sv
// Observation bundle between a FIFO under test and the magic-packet checker.
// The FIFO side drives the strobes and data; the checker returns its tracking status.
interface magic_packet_checker_if #(
    parameter int WIDTH  = 8,
    parameter int CNTWID = 4
);
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              capture;
    logic [1:0]        state;
    logic [CNTWID-1:0] cnt;
    logic [WIDTH-1:0]  magic_data;
    logic              done;
    logic              mismatch;
    logic              count_err;
    logic              prop_ok;

    modport master (
        output push, pop, data_in, data_out, capture,
        input  state, cnt, magic_data, done, mismatch, count_err, prop_ok
    );

    modport slave (
        input  push, pop, data_in, data_out, capture,
        output state, cnt, magic_data, done, mismatch, count_err, prop_ok
    );
endinterface

// File: rtl/magic_packet_checker.sv
// Captures one designated word pushed into a FIFO, follows it to the head and
// flags a sticky mismatch if it leaves with different data.
//
//   state | meaning
//   IDLE  | counting FIFO occupancy, waiting for a push with capture
//   TRACK | magic word stored, cnt = entries still ahead of it
//   DONE  | magic word has exited; everything frozen until reset
module magic_packet_checker #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    magic_packet_checker_if.slave  mp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2,
        BAD   = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNTWID-1:0] cnt_q;
    logic [WIDTH-1:0]  magic_q;
    logic              mismatch_q;
    logic              count_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            magic_q     <= '0;
            mismatch_q  <= 1'b0;
            count_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mp.pop && (cnt_q == '0)) begin
                        count_err_q <= 1'b1;
                    end
                    if (mp.capture && mp.push) begin
                        // The captured push is not counted; it is the tracked word itself.
                        magic_q <= mp.data_in;
                        state_q <= TRACK;
                        if (mp.pop && (cnt_q != '0)) begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end else begin
                        if (mp.push && !mp.pop && (cnt_q == CNTWID'(DEPTH))) begin
                            count_err_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + CNTWID'(mp.push) - CNTWID'(mp.pop);
                    end
                end
                TRACK: begin
                    if (mp.pop) begin
                        if (cnt_q == '0) begin
                            if (mp.data_out != magic_q) begin
                                mismatch_q <= 1'b1;
                            end
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mp.state      = state_q;
    assign mp.cnt        = cnt_q;
    assign mp.magic_data = magic_q;
    assign mp.done       = (state_q == DONE);
    assign mp.mismatch   = mismatch_q;
    assign mp.count_err  = count_err_q;
    assign mp.prop_ok    = ~mismatch_q;

endmodule

// File: tb/tb_magic_packet_checker.sv
// Directed bench for magic_packet_checker: one vector table for the basic
// capture/exit flow, then hand-written multi-cycle corner sequences.
module tb_magic_packet_checker;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int CNTWID = 4;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    magic_packet_checker_if #(.WIDTH(WIDTH), .CNTWID(CNTWID)) mp ();

    magic_packet_checker #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTWID(CNTWID)) dut (
        .clk (clk),
        .rst (rst),
        .mp  (mp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              push;
        logic              pop;
        logic              cap;
        logic [WIDTH-1:0]  di;
        logic [WIDTH-1:0]  dout;
        logic [1:0]        st;
        logic [CNTWID-1:0] cnt;
        logic [WIDTH-1:0]  mg;
        logic              mm;
        logic              ce;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic c,
                        input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dout);
        mp.push     = p;
        mp.pop      = q;
        mp.capture  = c;
        mp.data_in  = di;
        mp.data_out = dout;
        @(posedge clk);
        #1;
        mp.push    = 1'b0;
        mp.pop     = 1'b0;
        mp.capture = 1'b0;
    endtask

    task automatic do_reset();
        mp.push = 1'b0; mp.pop = 1'b0; mp.capture = 1'b0;
        mp.data_in = '0; mp.data_out = '0;
        rst = 1'b1;
        #3;
        check("rst_state", 32'(mp.state), 32'd0);
        check("rst_cnt", 32'(mp.cnt), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;

        //           push  pop   cap   di     dout   st    cnt  magic  mm    ce
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 2'd0, 4'd1, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 2'd0, 4'd2, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 2'd0, 4'd3, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 2'd1, 4'd3, 8'h5A, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'hEE, 8'h11, 2'd1, 4'd2, 8'h5A, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 2'd1, 4'd1, 8'h5A, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 2'd1, 4'd0, 8'h5A, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 2'd2, 4'd0, 8'h5A, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 8'h99, 8'h00, 2'd2, 4'd0, 8'h5A, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 2'd2, 4'd0, 8'h5A, 1'b0, 1'b0};

        do_reset();
        check("rst_magic", 32'(mp.magic_data), 32'd0);
        check("rst_mismatch", 32'(mp.mismatch), 32'd0);
        check("rst_count_err", 32'(mp.count_err), 32'd0);
        check("rst_prop_ok", 32'(mp.prop_ok), 32'd1);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].cap, tbl[i].di, tbl[i].dout);
            check($sformatf("vec%0d_state", i), 32'(mp.state), 32'(tbl[i].st));
            check($sformatf("vec%0d_cnt", i), 32'(mp.cnt), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_magic", i), 32'(mp.magic_data), 32'(tbl[i].mg));
            check($sformatf("vec%0d_mismatch", i), 32'(mp.mismatch), 32'(tbl[i].mm));
            check($sformatf("vec%0d_count_err", i), 32'(mp.count_err), 32'(tbl[i].ce));
            check($sformatf("vec%0d_done", i), 32'(mp.done), 32'(tbl[i].st == 2'd2));
            check($sformatf("vec%0d_prop_ok", i), 32'(mp.prop_ok), 32'(!tbl[i].mm));
        end

        // Wrong exit data, then sticky through further traffic
        do_reset();
        step(1, 0, 0, 8'h11, 8'h00);
        step(1, 0, 0, 8'h22, 8'h00);
        step(1, 0, 0, 8'h33, 8'h00);
        step(1, 0, 1, 8'h5A, 8'h00);
        step(0, 1, 0, 8'h00, 8'h11);
        step(0, 1, 0, 8'h00, 8'h22);
        step(0, 1, 0, 8'h00, 8'h33);
        step(0, 1, 0, 8'h00, 8'h5B);
        check("bad_exit_mismatch", 32'(mp.mismatch), 32'd1);
        check("bad_exit_prop_ok", 32'(mp.prop_ok), 32'd0);
        check("bad_exit_done", 32'(mp.done), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 8'h5A, 8'h5A);
            check($sformatf("sticky%0d_mismatch", i), 32'(mp.mismatch), 32'd1);
            check($sformatf("sticky%0d_prop_ok", i), 32'(mp.prop_ok), 32'd0);
        end

        // Simultaneous capture and pop at cnt=2
        do_reset();
        step(1, 0, 0, 8'h01, 8'h00);
        step(1, 0, 0, 8'h02, 8'h00);
        step(1, 1, 1, 8'hC3, 8'h01);
        check("simul_cnt", 32'(mp.cnt), 32'd1);
        check("simul_state", 32'(mp.state), 32'd1);
        check("simul_magic", 32'(mp.magic_data), 32'hC3);

        // Capture into an empty FIFO
        do_reset();
        step(1, 0, 1, 8'h77, 8'h00);
        check("empty_cap_cnt", 32'(mp.cnt), 32'd0);
        check("empty_cap_state", 32'(mp.state), 32'd1);
        step(0, 1, 0, 8'h00, 8'h77);
        check("empty_cap_done", 32'(mp.done), 32'd1);
        check("empty_cap_mismatch", 32'(mp.mismatch), 32'd0);
        check("empty_cap_count_err", 32'(mp.count_err), 32'd0);

        // Underflow in IDLE wraps cnt; later capture still accepted
        do_reset();
        step(0, 1, 0, 8'h00, 8'h00);
        check("underflow_err", 32'(mp.count_err), 32'd1);
        check("underflow_cnt", 32'(mp.cnt), 32'd15);
        step(1, 0, 1, 8'h44, 8'h00);
        check("underflow_cap_state", 32'(mp.state), 32'd1);
        check("underflow_cap_magic", 32'(mp.magic_data), 32'h44);

        // Overflow: DEPTH pushes are legal, the next one flags
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(i), 8'h00);
        check("full_cnt", 32'(mp.cnt), 32'd8);
        check("full_no_err", 32'(mp.count_err), 32'd0);
        step(1, 0, 0, 8'hFF, 8'h00);
        check("overflow_err", 32'(mp.count_err), 32'd1);
        check("overflow_cnt", 32'(mp.cnt), 32'd9);
        step(1, 0, 1, 8'hAB, 8'h00);
        check("overflow_cap_state", 32'(mp.state), 32'd1);
        check("overflow_cap_cnt", 32'(mp.cnt), 32'd9);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 8'h00, 8'h00);
        check("overflow_drain_cnt", 32'(mp.cnt), 32'd0);
        step(0, 1, 0, 8'h00, 8'hAB);
        check("overflow_exit_done", 32'(mp.done), 32'd1);
        check("overflow_exit_mismatch", 32'(mp.mismatch), 32'd0);
        check("overflow_err_sticky", 32'(mp.count_err), 32'd1);

        // Asynchronous reset while tracking
        do_reset();
        step(1, 0, 0, 8'h01, 8'h00);
        step(1, 0, 0, 8'h02, 8'h00);
        step(1, 0, 1, 8'h3C, 8'h00);
        check("pre_arst_state", 32'(mp.state), 32'd1);
        check("pre_arst_cnt", 32'(mp.cnt), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(mp.state), 32'd0);
        check("arst_cnt", 32'(mp.cnt), 32'd0);
        check("arst_magic", 32'(mp.magic_data), 32'd0);
        #1;
        rst = 1'b0;
        step(1, 0, 1, 8'h99, 8'h00);
        check("post_arst_state", 32'(mp.state), 32'd1);
        check("post_arst_magic", 32'(mp.magic_data), 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
